// File: rtl/mat_fetch_if.sv
// Handshake/bus bundle for mat_fetch_ctrl.
// Optional stall_cnt signal present only when MAT_FETCH_STALLCNT_EN is defined.
interface mat_fetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [7:0]        num_mat;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [DATA_W-1:0] m1_d0, m1_d1, m1_d2, m1_d3;
  logic [DATA_W-1:0] m2_d0, m2_d1, m2_d2, m2_d3;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a0, a1, a2, a3;
  logic [DATA_W-1:0] b0, b1, b2, b3;
  logic              busy;
  logic              done;
`ifdef MAT_FETCH_STALLCNT_EN
  logic [15:0]       stall_cnt;
`endif

  modport master (
    output start, num_mat, m1_d0, m1_d1, m1_d2, m1_d3, m2_d0, m2_d1, m2_d2, m2_d3, out_ready,
    input  rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3, out_valid,
    input  a0, a1, a2, a3, b0, b1, b2, b3, busy, done
`ifdef MAT_FETCH_STALLCNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, num_mat, m1_d0, m1_d1, m1_d2, m1_d3, m2_d0, m2_d1, m2_d2, m2_d3, out_ready,
    output rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3, out_valid,
    output a0, a1, a2, a3, b0, b1, b2, b3, busy, done
`ifdef MAT_FETCH_STALLCNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/mat_fetch_ctrl.sv
// Fetches num_mat 2x2 matrix pairs into a 2-entry FIFO feeding the multiplier pipeline.
// Define MAT_FETCH_STALLCNT_EN to add the saturating stall_cnt output.
module mat_fetch_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input logic        clk,
  input logic        rst,
  mat_fetch_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  localparam int unsigned EntryW = 8 * DATA_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        issue_q, issue_d, xfer_q, xfer_d;
  logic              inflight_q;
  logic [1:0]        count_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [EntryW-1:0] mem_q [2];
  logic [EntryW-1:0] wr_data, head;
  logic              accept, rd_en, push, pop, out_valid, run;
  logic [2:0]        occ;

  assign accept    = (state_q == StIdle) && bus.start;
  assign run       = (state_q == StRun);
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  assign push      = inflight_q;
  // Occupancy seen by the issue logic: stored + in flight, minus the entry leaving now.
  assign occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign wr_data   = {bus.m2_d3, bus.m2_d2, bus.m2_d1, bus.m2_d0,
                      bus.m1_d3, bus.m1_d2, bus.m1_d1, bus.m1_d0};
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    issue_d = issue_q;
    xfer_d  = xfer_q;
    rd_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          base_d  = '0;
          issue_d = bus.num_mat;
          xfer_d  = bus.num_mat;
          state_d = (bus.num_mat == 8'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        rd_en = (issue_q != 8'd0) && (occ < 3'd2);
        if (rd_en) begin
          base_d  = base_q + ADDR_W'(4);
          issue_d = issue_q - 8'd1;
        end
        if (pop) begin
          xfer_d = xfer_q - 8'd1;
          if (xfer_q == 8'd1) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      issue_q    <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      issue_q    <= issue_d;
      xfer_q     <= xfer_d;
      inflight_q <= rd_en;
      count_q    <= count_q + 2'(push) - 2'(pop);
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr0  = run ? base_q                 : '0;
  assign bus.rd_addr1  = run ? base_q + ADDR_W'(1)    : '0;
  assign bus.rd_addr2  = run ? base_q + ADDR_W'(2)    : '0;
  assign bus.rd_addr3  = run ? base_q + ADDR_W'(3)    : '0;
  assign bus.out_valid = out_valid;
  assign bus.a0        = head[0*DATA_W +: DATA_W];
  assign bus.a1        = head[1*DATA_W +: DATA_W];
  assign bus.a2        = head[2*DATA_W +: DATA_W];
  assign bus.a3        = head[3*DATA_W +: DATA_W];
  assign bus.b0        = head[4*DATA_W +: DATA_W];
  assign bus.b1        = head[5*DATA_W +: DATA_W];
  assign bus.b2        = head[6*DATA_W +: DATA_W];
  assign bus.b3        = head[7*DATA_W +: DATA_W];
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);

`ifdef MAT_FETCH_STALLCNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_q <= '0;
    end else if (out_valid && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: doc/mat_fetch_ctrl.md
MAT_FETCH_CTRL -- requirements
Module: mat_fetch_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as in the codebase: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 The block SHALL have parameter ADDR_W, default 8, address width.
REQ-003 The block SHALL have parameter DATA_W, default 8, element width.
REQ-004 start  in  1  request to begin a job; sampled only in IDLE.
REQ-005 num_mat  in  8  number of 2x2 matrix pairs to fetch; latched on start acceptance.
REQ-006 rd_en  out  1  read strobe shared by both operand memories.
REQ-007 rd_addr0..rd_addr3  out  ADDR_W each  element addresses base+0..base+3.
REQ-008 m1_d0..m1_d3, m2_d0..m2_d3  in  DATA_W each  memory read data, valid exactly 1 cycle after rd_en.
REQ-009 out_valid  out  1  matrix pair available to the multiplier pipeline.
REQ-010 out_ready  in  1  pipeline accepts pair; transfer occurs when out_valid && out_ready.
REQ-011 a0..a3, b0..b3  out  DATA_W each  matrix-1 / matrix-2 elements of the head pair.
REQ-012 busy  out  1  high from start acceptance through the done cycle inclusive.
REQ-013 done  out  1  single-cycle pulse when the last pair transfers.

Function
REQ-014 FSM states SHALL be: IDLE, RUN, DONE.
REQ-015 IDLE->RUN SHALL occur on start=1 with num_mat!=0; base is cleared to 0, and issue and transfer counts are loaded with num_mat.
REQ-016 IDLE->DONE SHALL occur on start=1 with num_mat==0: no rd_en and no out_valid; done pulses the next cycle.
REQ-017 start SHALL be ignored in RUN and DONE.
REQ-018 rd_addrN SHALL equal base+N, modulo 2^ADDR_W.
REQ-019 base SHALL increment by 4 on every rd_en cycle and wrap 8'hFC->8'h00.
REQ-020 A 2-entry output FIFO SHALL hold fetched pairs.
REQ-021 rd_en SHALL assert in RUN iff issues remain and (FIFO occupancy + reads in flight) < 2, counting this cycle's pop.
REQ-022 The FIFO SHALL never overflow.
REQ-023 With out_ready held 1, throughput SHALL be 1 pair/cycle, and first out_valid SHALL be 2 cycles after start acceptance.
REQ-024 Read data SHALL be captured into the FIFO in the cycle after rd_en.
REQ-025 out_valid SHALL equal FIFO non-empty, and a*/b* SHALL show the head entry.
REQ-026 a*/b* SHALL stay stable while out_valid && !out_ready.
REQ-027 Simultaneous push and pop SHALL both occur; occupancy is unchanged.
REQ-028 RUN->DONE SHALL occur on the cycle the final pair transfers.
REQ-029 DONE SHALL last 1 cycle (done=1, busy=1), then go to IDLE.
REQ-030 Transfer order SHALL equal issue order.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL set FSM=IDLE, base=0, counts=0, FIFO empty, in-flight flag cleared.
REQ-032 On rst=1, all outputs SHALL go to 0: rd_en, rd_addr*, out_valid, a*, b*, busy, done, and stall_cnt when present.
REQ-033 Reset mid-job SHALL abort the job: data returning the cycle after reset is discarded, and no done pulse occurs.
REQ-034 rst SHALL take priority over start in the same cycle.

Configuration
REQ-035 Macro MAT_FETCH_STALLCNT_EN SHALL control an extra output port stall_cnt, out, 16 bits.
REQ-036 With MAT_FETCH_STALLCNT_EN defined, stall_cnt SHALL count cycles with out_valid && !out_ready, saturate at 16'hFFFF, and clear on start acceptance and on rst.
REQ-037 Without MAT_FETCH_STALLCNT_EN, the stall_cnt port and its logic SHALL be absent, with no other behavioural change.

Verification
REQ-038 The bench SHALL cover: rst, start, num_mat=3, out_ready=1 -> rd_addr0 = 0,4,8 on consecutive cycles; 3 transfers back-to-back; done 1 cycle after the last transfer cycle; busy for 6 cycles.
REQ-039 The bench SHALL cover: num_mat=4, out_ready=0 for 10 cycles then 1 -> exactly 2 rd_en issued before release; outputs stable while stalled; all 4 pairs delivered in order; stall_cnt=10 when enabled.
REQ-040 The bench SHALL cover: num_mat=0 -> no rd_en, no out_valid, done pulses the cycle after start, back to IDLE.
REQ-041 The bench SHALL cover: num_mat=65, out_ready=1 -> 65th fetch at rd_addr0=8'h00 (wrap), rd_addr3=8'h03.
REQ-042 The bench SHALL cover: rst asserted 3 cycles into a num_mat=5 job -> all outputs 0 next cycle; no done; a new start is accepted normally afterwards.
REQ-043 The bench SHALL cover: start pulsed again during RUN -> ignored; pair count and addresses unaffected.
